// File: rtl/sha256_padder.sv
// SHA-256 message padder.
// Streams message bytes into a 64-byte block buffer and appends the 0x80
// marker, the zero fill and the 64-bit big-endian bit length. Each full
// block is handed to the hash core with a one-cycle START pulse, and the
// buffer is held steady until the core reports CORE_DONE.
//
// Handshakes:
//   DIN: a byte moves on a cycle with DIN_VALID && DIN_READY. DIN_READY is
//        decoded from state only (high in ACCEPT), so it never depends on
//        DIN_VALID in the same cycle.
//   Core: START is a single-cycle request. SHA512IN stays stable from the
//        START cycle through the cycle CORE_DONE is seen in WAIT.
//        CORE_DONE in any other state is ignored.
module sha256_padder #(
  parameter int LEN_W = 64
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [7:0]   DIN,
  input  logic         DIN_VALID,
  input  logic         DIN_LAST,
  output logic         DIN_READY,
  output logic         START,
  output logic [511:0] SHA512IN,
  input  logic         CORE_DONE,
  output logic         MSG_DONE,
  output logic         BUSY,
  output logic [2:0]   DBG_STATE
);

  localparam logic [2:0] S_ACCEPT = 3'd0;
  localparam logic [2:0] S_PAD    = 3'd1;
  localparam logic [2:0] S_LEN    = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;

  // Last zero-fill byte before the length field, and the last byte of a block.
  localparam logic [5:0] PTR_FILL_END = 6'd55;
  localparam logic [5:0] PTR_BLK_END  = 6'd63;

  logic [2:0]       state;
  logic [5:0]       ptr;
  logic [LEN_W-1:0] bitlen;
  logic             last_seen;
  logic             one_written;
  logic             final_blk;
  logic             in_msg;
  logic             msg_done_q;
  logic [511:0]     blk;

  logic [5:0]       bidx;
  logic [63:0]      len64;
  logic             wr_en;
  logic [7:0]       wr_data;
  logic             clr_buf;

  // Byte 0 lives in the top bits, so the bit offset counts down from ptr.
  assign bidx  = PTR_BLK_END - ptr;
  assign len64 = 64'(bitlen);

  assign DIN_READY = (state == S_ACCEPT);
  assign START     = (state == S_START);
  assign SHA512IN  = blk;
  assign MSG_DONE  = msg_done_q;
  assign BUSY      = !((state == S_ACCEPT) && (ptr == 6'd0) && !in_msg);
  assign DBG_STATE = state;

  // Select the byte written into the buffer this cycle, if any.
  always_comb begin
    wr_en   = 1'b0;
    wr_data = 8'h00;
    clr_buf = 1'b0;
    case (state)
      S_ACCEPT: begin
        wr_en   = DIN_VALID;
        wr_data = DIN;
      end
      S_PAD: begin
        wr_en   = 1'b1;
        wr_data = one_written ? 8'h00 : 8'h80;
      end
      S_LEN: begin
        wr_en   = 1'b1;
        wr_data = len64[{bidx[2:0], 3'b000} +: 8];
      end
      S_WAIT: begin
        clr_buf = CORE_DONE;
      end
      default: begin
        wr_en = 1'b0;
      end
    endcase
  end

  // Block buffer: byte writes at ptr, wiped once the core has consumed it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      blk <= '0;
    end else if (clr_buf) begin
      blk <= '0;
    end else if (wr_en) begin
      blk[{bidx, 3'b000} +: 8] <= wr_data;
    end
  end

  // Sequencing of accept / pad / length / core hand-off, plus message flags.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= S_ACCEPT;
      ptr         <= 6'd0;
      bitlen      <= '0;
      last_seen   <= 1'b0;
      one_written <= 1'b0;
      final_blk   <= 1'b0;
      in_msg      <= 1'b0;
      msg_done_q  <= 1'b0;
    end else begin
      msg_done_q <= 1'b0;
      case (state)
        S_ACCEPT: begin
          if (DIN_VALID) begin
            ptr    <= ptr + 6'd1;
            bitlen <= bitlen + LEN_W'(8);
            in_msg <= 1'b1;
            if (DIN_LAST) begin
              last_seen <= 1'b1;
            end
            // A full block goes out first; padding resumes in the next block.
            if (ptr == PTR_BLK_END) begin
              state <= S_START;
            end else if (DIN_LAST) begin
              state <= S_PAD;
            end
          end
        end
        S_PAD: begin
          one_written <= 1'b1;
          ptr         <= ptr + 6'd1;
          if (ptr == PTR_FILL_END) begin
            state <= S_LEN;
          end else if (ptr == PTR_BLK_END) begin
            state <= S_START;
          end
        end
        S_LEN: begin
          ptr <= ptr + 6'd1;
          if (ptr == PTR_BLK_END) begin
            final_blk <= 1'b1;
            state     <= S_START;
          end
        end
        S_START: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (CORE_DONE) begin
            ptr <= 6'd0;
            if (final_blk) begin
              state       <= S_ACCEPT;
              msg_done_q  <= 1'b1;
              bitlen      <= '0;
              last_seen   <= 1'b0;
              one_written <= 1'b0;
              final_blk   <= 1'b0;
              in_msg      <= 1'b0;
            end else if (last_seen) begin
              state <= S_PAD;
            end else begin
              state <= S_ACCEPT;
            end
          end
        end
        default: begin
          state <= S_ACCEPT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_padder.sv
// Bench for sha256_padder: directed messages, a byte-level padding model
// that builds the expected blocks, and a per-cycle compare process.
module tb_sha256_padder;

  logic         CLK;
  logic         RST;
  logic [7:0]   DIN;
  logic         DIN_VALID;
  logic         DIN_LAST;
  logic         DIN_READY;
  logic         START;
  logic [511:0] SHA512IN;
  logic         CORE_DONE;
  logic         MSG_DONE;
  logic         BUSY;
  logic [2:0]   DBG_STATE;

  sha256_padder #(.LEN_W(64)) dut (
    .CLK(CLK), .RST(RST), .DIN(DIN), .DIN_VALID(DIN_VALID), .DIN_LAST(DIN_LAST),
    .DIN_READY(DIN_READY), .START(START), .SHA512IN(SHA512IN),
    .CORE_DONE(CORE_DONE), .MSG_DONE(MSG_DONE), .BUSY(BUSY), .DBG_STATE(DBG_STATE)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [511:0] exp_q[$];
  logic         last_q[$];
  logic [511:0] model_blk[0:3];
  int           model_n;
  logic [7:0]   msg_b[0:255];
  int           acc_cyc;
  int           core_delay = 1;
  logic         hold_core  = 1'b0;
  logic         poke_tgl   = 1'b0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Padding model: message, 0x80, zeros, 64-bit big-endian bit count,
  // sliced into 64-byte blocks with byte 0 in the top bits.
  task automatic model_build(input int n);
    logic [7:0]  pb[0:255];
    logic [63:0] len;
    int total;
    model_n = (n + 72) / 64;
    total   = model_n * 64;
    for (int i = 0; i < 256; i++) pb[i] = 8'h00;
    for (int i = 0; i < n; i++) pb[i] = msg_b[i];
    pb[n] = 8'h80;
    len = 64'(n) * 64'd8;
    for (int k = 0; k < 8; k++) pb[total - 8 + k] = len[63 - 8*k -: 8];
    for (int b = 0; b < 4; b++) begin
      model_blk[b] = '0;
      for (int i = 0; i < 64; i++)
        if (b < model_n) model_blk[b][511 - 8*i -: 8] = pb[b*64 + i];
    end
  endtask

  task automatic push_expected(input int n);
    model_build(n);
    for (int b = 0; b < model_n; b++) begin
      exp_q.push_back(model_blk[b]);
      last_q.push_back(b == model_n - 1);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the byte is taken.
  task automatic send_byte(input logic [7:0] b, input logic last);
    logic rdy;
    int   k = 0;
    DIN = b; DIN_VALID = 1'b1; DIN_LAST = last;
    forever begin
      @(negedge CLK);
      rdy = DIN_READY;
      if (rdy) acc_cyc = cyc;
      @(posedge CLK);
      if (rdy) break;
      k++;
      if (k > 500) begin
        check("din_ready_timeout", 512'(0), 512'(1));
        break;
      end
    end
    #1;
    DIN_VALID = 1'b0; DIN_LAST = 1'b0; DIN = 8'h00;
  endtask

  task automatic send_msg(input int n, input logic with_last);
    for (int i = 0; i < n; i++) send_byte(msg_b[i], with_last && (i == n - 1));
  endtask

  task automatic wait_start(output int c);
    int k = 0;
    c = 0;
    forever begin
      @(negedge CLK);
      if (START) begin c = cyc; break; end
      k++;
      if (k > 1000) begin check("start_timeout", 512'(0), 512'(1)); break; end
    end
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    forever begin
      @(negedge CLK);
      if (MSG_DONE) break;
      k++;
      if (k > 2000) begin check({name, "_done_timeout"}, 512'(0), 512'(1)); break; end
    end
    check({name, "_blocks_left"}, 512'(exp_q.size()), 512'(0));
  endtask

  // Hash core stand-in: answers each START after core_delay cycles.
  // A toggle on poke_tgl requests a stray CORE_DONE pulse.
  initial begin
    logic poke_seen;
    CORE_DONE = 1'b0;
    poke_seen = 1'b0;
    forever begin
      @(negedge CLK);
      if (START && !hold_core) begin
        repeat (core_delay) @(posedge CLK);
        #1 CORE_DONE = 1'b1;
        @(posedge CLK);
        #1 CORE_DONE = 1'b0;
      end else if (poke_tgl != poke_seen) begin
        poke_seen = poke_tgl;
        @(posedge CLK);
        #1 CORE_DONE = 1'b1;
        @(posedge CLK);
        #1 CORE_DONE = 1'b0;
      end
    end
  end

  // ---------------- compare process ----------------
  initial begin
    logic [511:0] cur;
    logic         cur_last;
    logic         pending;
    logic         done_next;
    logic         bad;
    cur = '0; cur_last = 1'b0; pending = 1'b0; done_next = 1'b0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        exp_q.delete(); last_q.delete();
        pending = 1'b0; done_next = 1'b0;
        check("rst_start", 512'(START), 512'(0));
        check("rst_msg_done", 512'(MSG_DONE), 512'(0));
        check("rst_block", SHA512IN, 512'(0));
      end else begin
        check("msg_done", 512'(MSG_DONE), 512'(done_next));
        done_next = 1'b0;
        if (START) begin
          bad = pending || (exp_q.size() == 0);
          check("start_expected", 512'(bad), 512'(0));
          if (!bad) begin
            cur = exp_q.pop_front();
            cur_last = last_q.pop_front();
            check("block", SHA512IN, cur);
            pending = 1'b1;
          end
        end else if (pending) begin
          check("hold_block", SHA512IN, cur);
          check("hold_ready", 512'(DIN_READY), 512'(0));
          if (CORE_DONE) begin
            pending = 1'b0;
            done_next = cur_last;
          end
        end
      end
    end
  end

  // ---------------- directed tests ----------------
  initial begin
    int s_cyc;
    logic [511:0] raw;
    RST = 1'b1; DIN = 8'h00; DIN_VALID = 1'b0; DIN_LAST = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("idle_ready", 512'(DIN_READY), 512'(1));
    check("idle_busy", 512'(BUSY), 512'(0));
    @(posedge CLK); #1;

    // "abc"
    msg_b[0] = 8'h61; msg_b[1] = 8'h62; msg_b[2] = 8'h63;
    model_build(3);
    check("pin_abc_nblk", 512'(model_n), 512'(1));
    check("pin_abc", model_blk[0], {32'h61626380, 416'h0, 64'h18});
    push_expected(3);
    send_msg(3, 1'b1);
    wait_start(s_cyc);
    check("lat_abc", 512'(s_cyc - acc_cyc), 512'(62));
    wait_done("abc");
    @(negedge CLK);
    check("after_abc_busy", 512'(BUSY), 512'(0));
    @(posedge CLK); #1;

    // 55 bytes of 0x41
    for (int i = 0; i < 55; i++) msg_b[i] = 8'h41;
    model_build(55);
    check("pin_55_nblk", 512'(model_n), 512'(1));
    check("pin_55", model_blk[0], {{55{8'h41}}, 8'h80, 64'h1B8});
    push_expected(55);
    send_msg(55, 1'b1);
    wait_start(s_cyc);
    check("lat_55", 512'(s_cyc - acc_cyc), 512'(10));
    wait_done("m55");
    @(posedge CLK); #1;

    // 56 bytes of 0x41
    for (int i = 0; i < 56; i++) msg_b[i] = 8'h41;
    model_build(56);
    check("pin_56_nblk", 512'(model_n), 512'(2));
    check("pin_56_b1", model_blk[0], {{56{8'h41}}, 8'h80, 56'h0});
    check("pin_56_b2", model_blk[1], {448'h0, 64'h1C0});
    push_expected(56);
    send_msg(56, 1'b1);
    wait_done("m56");
    @(posedge CLK); #1;

    // 64 bytes 0x00..0x3F
    for (int i = 0; i < 64; i++) msg_b[i] = 8'(i);
    raw = '0;
    for (int i = 0; i < 64; i++) raw[511 - 8*i -: 8] = 8'(i);
    model_build(64);
    check("pin_64_b1", model_blk[0], raw);
    check("pin_64_b2", model_blk[1], {8'h80, 440'h0, 64'h200});
    push_expected(64);
    send_msg(64, 1'b1);
    wait_done("m64");
    @(posedge CLK); #1;

    // 63, 1 and 120 byte messages with random content
    for (int i = 0; i < 120; i++) msg_b[i] = 8'($urandom_range(0, 255));
    push_expected(63);  send_msg(63, 1'b1);  wait_done("m63");
    @(posedge CLK); #1;
    push_expected(1);   send_msg(1, 1'b1);   wait_done("m1");
    @(posedge CLK); #1;
    push_expected(120); send_msg(120, 1'b1); wait_done("m120");
    @(posedge CLK); #1;

    // Slow core: buffer frozen and input stalled for 100 cycles
    core_delay = 100;
    msg_b[0] = 8'h61; msg_b[1] = 8'h62; msg_b[2] = 8'h63;
    push_expected(3);
    send_msg(3, 1'b1);
    wait_start(s_cyc);
    repeat (50) @(negedge CLK);
    check("slow_ready", 512'(DIN_READY), 512'(0));
    check("slow_busy", 512'(BUSY), 512'(1));
    wait_done("slow");
    core_delay = 1;
    @(posedge CLK); #1;

    // Stray CORE_DONE while idle and mid-message in ACCEPT
    poke_tgl = ~poke_tgl;
    repeat (4) @(posedge CLK); #1;
    @(negedge CLK);
    check("poke_idle_busy", 512'(BUSY), 512'(0));
    check("poke_idle_ready", 512'(DIN_READY), 512'(1));
    @(posedge CLK); #1;
    msg_b[0] = 8'h68; msg_b[1] = 8'h69;
    push_expected(2);
    send_byte(msg_b[0], 1'b0);
    poke_tgl = ~poke_tgl;
    repeat (4) @(posedge CLK); #1;
    @(negedge CLK);
    check("poke_mid_busy", 512'(BUSY), 512'(1));
    check("poke_mid_ready", 512'(DIN_READY), 512'(1));
    @(posedge CLK); #1;
    send_byte(msg_b[1], 1'b1);
    wait_done("hi");
    @(posedge CLK); #1;

    // Reset while block 1 of a 100-byte message waits on the core
    hold_core = 1'b1;
    for (int i = 0; i < 100; i++) msg_b[i] = 8'($urandom_range(0, 255));
    raw = '0;
    for (int i = 0; i < 64; i++) raw[511 - 8*i -: 8] = msg_b[i];
    exp_q.push_back(raw);
    last_q.push_back(1'b0);
    send_msg(64, 1'b0);
    wait_start(s_cyc);
    repeat (5) @(posedge CLK);
    #1 RST = 1'b1;
    @(negedge CLK);
    check("rst_wait_start", 512'(START), 512'(0));
    check("rst_wait_block", SHA512IN, 512'(0));
    @(posedge CLK);
    #1 RST = 1'b0;
    hold_core = 1'b0;
    @(negedge CLK);
    check("post_rst_ready", 512'(DIN_READY), 512'(1));
    check("post_rst_busy", 512'(BUSY), 512'(0));
    @(posedge CLK); #1;
    msg_b[0] = 8'h61; msg_b[1] = 8'h62; msg_b[2] = 8'h63;
    push_expected(3);
    send_msg(3, 1'b1);
    wait_done("abc_after_rst");
    repeat (5) @(posedge CLK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_padder.md
SHA256_PADDER -- requirements
Module: sha256_padder

Interface
REQ-001 Parameter: LEN_W, default 64, width of the message bit-length counter; the length field is always 64 bits, zero-extended from LEN_W.
REQ-002 CLK  input  1  sole clock, all state updates on posedge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 DIN  input  8  message byte.
REQ-005 DIN_VALID  input  1  DIN holds a valid byte.
REQ-006 DIN_LAST  input  1  qualifies DIN_VALID; the byte is the final byte of the message.
REQ-007 DIN_READY  output  1  byte accepted on a cycle when DIN_VALID && DIN_READY.
REQ-008 START  output  1  one-cycle request to the hash core to process SHA512IN.
REQ-009 SHA512IN  output  512  padded block; byte 0 at [511:504], byte 63 at [7:0].
REQ-010 CORE_DONE  input  1  hash core completed the current block.
REQ-011 MSG_DONE  output  1  one-cycle pulse: the final padded block of the message has completed.
REQ-012 BUSY  output  1  high in every state except ACCEPT with ptr==0 and no message in progress.

Function
REQ-013 States: ACCEPT, PAD, LEN, START, WAIT; a 6-bit byte pointer ptr; a LEN_W-bit counter bitlen; flags last_seen and one_written.
REQ-014 DIN_READY shall be high only in ACCEPT, decoded from state.
REQ-015 ACCEPT: each accepted byte is written at ptr, ptr increments by 1, and bitlen increments by 8 (modulo 2^LEN_W).
REQ-016 Accepted byte at ptr==63: next state START (block full); if DIN_LAST, set last_seen.
REQ-017 Accepted byte with DIN_LAST at ptr<63: set last_seen; next state PAD.
REQ-018 PAD, first cycle with one_written==0: write 0x80 at ptr; set one_written.
REQ-019 Later PAD cycles: write 0x00 at ptr.
REQ-020 PAD advances ptr one byte per cycle.
REQ-021 PAD exit: LEN after writing byte 55; START after writing byte 63 (0x80 landed at byte 56..63).
REQ-022 LEN: 8 cycles writing bitlen zero-extended to 64 bits, big-endian, into bytes 56..63; then START with the final flag set.
REQ-023 START: START=1 for exactly one cycle; next state WAIT.
REQ-024 WAIT: hold until CORE_DONE=1; SHA512IN stable from the START cycle through the CORE_DONE cycle.
REQ-025 On CORE_DONE in WAIT: buffer cleared to zero, ptr=0, then the next state is chosen:
  - final block -> ACCEPT, MSG_DONE=1 next cycle, bitlen/last_seen/one_written cleared;
  - last_seen && !final -> PAD (0x80 written if one_written==0, else zeros only);
  - otherwise -> ACCEPT.
REQ-026 CORE_DONE outside WAIT shall be ignored.
REQ-027 DIN_VALID outside ACCEPT shall be ignored, with no byte consumed.
REQ-028 Messages are at least 1 byte; zero-length messages are not supported.
REQ-029 Latency: DIN_LAST accepted at ptr p (p<55 before write) -> START asserted (55-p)+8+1 cycles later.
REQ-030 Exactly ceil((n+9)/64) START pulses per n-byte message.

Reset
REQ-031 RST=1 shall immediately force:
  - state ACCEPT, ptr=0, bitlen=0, flags=0, buffer/SHA512IN=0;
  - START=0, MSG_DONE=0;
  - DIN_READY=1 while RST=1 is not required; DIN_READY=1 on the first clock after release.
REQ-032 RST mid-message (any state) discards the message; the next message starts from bitlen=0 with no residual bytes.

Verification
REQ-033 "abc" (0x61,0x62,0x63, LAST on 3rd) -> one START; SHA512IN=61626380 followed by 0x00 bytes, ending 00000000_00000018; MSG_DONE one cycle after CORE_DONE.
REQ-034 55 bytes 0x41 -> one block; byte 55=0x80, bytes 56..63=0x00000000000001B8.
REQ-035 56 bytes 0x41 -> two STARTs.
  - block 1: byte 56=0x80, bytes 57..63=0x00;
  - block 2: bytes 0..55=0x00, length 0x1C0;
  - MSG_DONE only after the 2nd CORE_DONE.
REQ-036 64 bytes 0x00..0x3F, LAST on byte 63 -> block 1 is the raw data; block 2: byte 0=0x80, length 0x200.
REQ-037 CORE_DONE delayed 100 cycles -> DIN_READY=0 and SHA512IN unchanged throughout; CORE_DONE pulsed in ACCEPT has no effect.
REQ-038 RST pulsed during WAIT of block 1 of a 100-byte message -> START=0, MSG_DONE never fires; a following "abc" gives exactly the REQ-033 block.
